// File: rtl/nla_bram_pkg.sv
// nla_bram_pkg
// Constants and types shared by the BRAM-facing blocks of the approximation
// engine: the LUT reader in this slice and the coefficient loader that owns
// port B.
//   BRAM_RD_LATENCY : cycles from ena to stable douta (registered-output BRAM)
//   LUT_*           : default widths of the LUT BRAM and its request tags
//   lut_addr_t      : LUT address type shared with the loader
//   lut_tag_t       : request sideband tag type
package nla_bram_pkg;

  localparam int BRAM_RD_LATENCY = 2;

  localparam int LUT_RAM_WIDTH  = 32;
  localparam int LUT_ADDR_LINES = 4;
  localparam int LUT_TAG_WIDTH  = 4;

  typedef logic [LUT_ADDR_LINES-1:0] lut_addr_t;
  typedef logic [LUT_TAG_WIDTH-1:0]  lut_tag_t;

endpackage : nla_bram_pkg

// File: rtl/bram_lut_reader_if.sv
// bram_lut_reader_if
// Request and response streams of the LUT reader, both valid/ready.
//   in_valid_i / in_ready_o / in_idx_i / in_tag_i       : LUT index requests
//   out_valid_o / out_ready_i / out_data_o / out_tag_o  : LUT words + tags
// Signal suffixes are from the reader's point of view.
//   slave  : the reader (consumes requests, produces responses)
//   master : the index generator / interpolation datapath side
interface bram_lut_reader_if
  import nla_bram_pkg::*;
#(
  parameter int RAM_WIDTH  = LUT_RAM_WIDTH,
  parameter int ADDR_LINES = LUT_ADDR_LINES,
  parameter int TAG_WIDTH  = LUT_TAG_WIDTH
) ();

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ADDR_LINES-1:0] in_idx_i;
  logic [TAG_WIDTH-1:0]  in_tag_i;

  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [RAM_WIDTH-1:0]  out_data_o;
  logic [TAG_WIDTH-1:0]  out_tag_o;

  modport slave (
    input  in_valid_i, in_idx_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

  modport master (
    output in_valid_i, in_idx_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

endinterface : bram_lut_reader_if

// File: rtl/lut_resp_fifo.sv
// lut_resp_fifo
// Synchronous response FIFO. The head word is read straight from the storage
// flops, so an entry pushed at one edge is visible the following cycle.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   push_i        : write push_data_i (never asserted when full)
//   pop_i         : drop the head entry (ignored when empty)
//   valid_o       : FIFO non-empty
//   pop_data_o    : head entry, zero while empty
//   count_o       : current occupancy
// DEPTH must be a power of 2 so the pointers wrap by overflow.
module lut_resp_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign valid_o    = (count_q != '0);
  assign do_pop     = pop_i && valid_o;
  assign count_o    = count_q;
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

  // NOTE: storage is deliberately not reset; only pointers and count are.
  // Stale words are never observable because the output is gated by valid_o.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Upstream credit flow control guarantees room for every push.
  assert property (@(posedge clk_i) disable iff (!rstn_i) !(push_i && full));

endmodule : lut_resp_fifo

// File: rtl/bram_lut_reader.sv
// bram_lut_reader
// Read-side initiator for the registered-output dual-port LUT BRAM (port A).
// Takes LUT indices, adds base_addr_i (wrapping), issues reads, absorbs the
// fixed read latency and returns {data, tag} in request order with full
// back-pressure. A credit counter sized to the response FIFO throttles
// requests so every issued read has a guaranteed FIFO slot.
//   clk_i, rstn_i   : clock, asynchronous active-low reset
//   base_addr_i     : LUT base offset, sampled on each issue
//   s               : request/response streams (bram_lut_reader_if.slave)
//   bram_*_o/_i     : BRAM port A (read-only; wea tied low, rstna = rstn_i)
//   busy_o          : reads in flight or responses still queued
module bram_lut_reader
  import nla_bram_pkg::*;
#(
  parameter int RAM_WIDTH  = LUT_RAM_WIDTH,
  parameter int ADDR_LINES = LUT_ADDR_LINES,
  parameter int TAG_WIDTH  = LUT_TAG_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [ADDR_LINES-1:0] base_addr_i,
  bram_lut_reader_if.slave      s,
  output logic [ADDR_LINES-1:0] bram_addra_o,
  output logic                  bram_ena_o,
  output logic                  bram_wea_o,
  output logic                  bram_regcea_o,
  output logic                  bram_rstna_o,
  input  logic [RAM_WIDTH-1:0]  bram_douta_i,
  output logic                  busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = RAM_WIDTH + TAG_WIDTH;
  localparam int L  = BRAM_RD_LATENCY;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } stage_t;

  stage_t                pipe_q [L];
  logic [CW-1:0]         credits_q;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         fifo_rdata;
  logic [ADDR_LINES-1:0] rd_addr;
  logic                  issue, pop, push;

  assign s.in_ready_o = (credits_q != '0);
  assign issue        = s.in_valid_i && s.in_ready_o;
  assign pop          = s.out_valid_o && s.out_ready_i;
  assign push         = pipe_q[L-1].valid;

  // Same-width add: the carry falls off, so LUT addresses wrap.
  assign rd_addr       = base_addr_i + s.in_idx_i;
  assign bram_ena_o    = issue;
  assign bram_addra_o  = issue ? rd_addr : '0;
  assign bram_wea_o    = 1'b0;
  assign bram_regcea_o = pipe_q[0].valid;
  assign bram_rstna_o  = rstn_i;

  // Credits count free FIFO slots not yet claimed by an in-flight read.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      credits_q <= CW'(FIFO_DEPTH);
    end else begin
      case ({issue, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Stage 0 is valid during the cycle the BRAM output register loads;
  // the last stage marks douta as stable and is the FIFO push.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < L; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0].valid <= issue;
      pipe_q[0].tag   <= s.in_tag_i;
      for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // NOTE: both outputs get a value before the loop, so no path leaves them
  // unassigned and no latch is inferred.
  always_comb begin
    in_flight = '0;
    busy_o    = s.out_valid_o;
    for (int i = 0; i < L; i++) begin
      in_flight = in_flight + CW'(pipe_q[i].valid);
      busy_o    = busy_o | pipe_q[i].valid;
    end
  end

  lut_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .push_data_i ({pipe_q[L-1].tag, bram_douta_i}),
    .pop_i       (pop),
    .valid_o     (s.out_valid_o),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count)
  );

  assign s.out_tag_o  = fifo_rdata[FW-1 -: TAG_WIDTH];
  assign s.out_data_o = fifo_rdata[RAM_WIDTH-1:0];

  // Every claimed slot is either in the read pipeline or in the FIFO.
  assert property (@(posedge clk_i) disable iff (!rstn_i)
    (32'(credits_q) + 32'(fifo_count) + 32'(in_flight)) == 32'(FIFO_DEPTH));

endmodule : bram_lut_reader

// File: tb/tb_bram_lut_reader.sv
// tb_bram_lut_reader
// Directed bench for bram_lut_reader with a behavioural registered-output
// BRAM on port A. A queue-based model tracks outstanding requests (address
// resolved at issue, data taken from the memory image) and is compared with
// the DUT on every cycle; directed sequences add hand-computed expectations.
module tb_bram_lut_reader;
  import nla_bram_pkg::*;

  localparam int RW    = 32;
  localparam int AL    = 4;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  lut_addr_t     base_addr_i;
  logic [AL-1:0] bram_addra_o;
  logic          bram_ena_o, bram_wea_o, bram_regcea_o, bram_rstna_o;
  logic [RW-1:0] bram_douta_i;
  logic          busy_o;

  bram_lut_reader_if #(.RAM_WIDTH(RW), .ADDR_LINES(AL), .TAG_WIDTH(TW)) lut_if ();

  bram_lut_reader #(
    .RAM_WIDTH(RW), .ADDR_LINES(AL), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .base_addr_i   (base_addr_i),
    .s             (lut_if),
    .bram_addra_o  (bram_addra_o),
    .bram_ena_o    (bram_ena_o),
    .bram_wea_o    (bram_wea_o),
    .bram_regcea_o (bram_regcea_o),
    .bram_rstna_o  (bram_rstna_o),
    .bram_douta_i  (bram_douta_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Registered-output BRAM, port A: ena loads the internal register,
  // regcea moves it to douta, rstna clears douta.
  logic [RW-1:0] ram [16];
  logic [RW-1:0] bram_int;
  always @(posedge clk_i) if (bram_ena_o) bram_int <= ram[bram_addra_o];
  always @(posedge clk_i or negedge bram_rstna_o)
    if (!bram_rstna_o)     bram_douta_i <= '0;
    else if (bram_regcea_o) bram_douta_i <= bram_int;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [RW-1:0] data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  bit   prev_issue = 0;

  always @(negedge clk_i) begin
    bit   exp_ready, head_ready, issue;
    int   addr;
    exp_t e;
    cyc++;
    if (!rstn_i) begin
      check("m_rst_out_valid", lut_if.out_valid_o, 0);
      check("m_rst_in_ready",  lut_if.in_ready_o,  1);
      check("m_rst_busy",      busy_o,             0);
      exp_q.delete();
      prev_issue = 0;
    end else begin
      exp_ready  = exp_q.size() < DEPTH;
      head_ready = exp_q.size() > 0 && cyc >= exp_q[0].cyc + 3;
      issue      = lut_if.in_valid_i && exp_ready;
      check("m_in_ready",  lut_if.in_ready_o,  exp_ready);
      check("m_busy",      busy_o,             exp_q.size() != 0);
      check("m_regcea",    bram_regcea_o,      prev_issue);
      check("m_out_valid", lut_if.out_valid_o, head_ready);
      check("m_ena",       bram_ena_o,         issue);
      if (head_ready && lut_if.out_ready_i) begin
        e = exp_q.pop_front();
        check("m_out_data", lut_if.out_data_o, e.data);
        check("m_out_tag",  lut_if.out_tag_o,  e.tag);
      end
      if (issue) begin
        addr = (int'(base_addr_i) + int'(lut_if.in_idx_i)) % 16;
        check("m_addra", bram_addra_o, addr);
        e.data = ram[addr];
        e.tag  = lut_if.in_tag_i;
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
      prev_issue = issue;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int idx, input int tag);
    lut_if.in_valid_i = v;
    lut_if.in_idx_i   = AL'(idx);
    lut_if.in_tag_i   = TW'(tag);
  endtask

  task automatic wait_out(input int max);
    int n = 0;
    @(negedge clk_i);
    while (!lut_if.out_valid_o && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_out_valid", lut_if.out_valid_o, 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < max) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_idle_busy", busy_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h1000_0000 + i * 32'h0011_0101;
    ram[5] = 32'hDEAD_BEEF;
    ram[2] = 32'hC0DE_0002;
    rstn_i               = 1'b0;
    base_addr_i          = '0;
    lut_if.out_ready_i   = 1'b1;
    drive(0, 0, 0);

    // Reset values
    step(); step();
    check("rst_ena",      bram_ena_o,         0);
    check("rst_regcea",   bram_regcea_o,      0);
    check("rst_addra",    bram_addra_o,       0);
    check("rst_wea",      bram_wea_o,         0);
    check("rst_rstna",    bram_rstna_o,       0);
    check("rst_in_ready", lut_if.in_ready_o,  1);
    check("rst_out_valid",lut_if.out_valid_o, 0);
    check("rst_out_data", lut_if.out_data_o,  0);
    check("rst_out_tag",  lut_if.out_tag_o,   0);
    check("rst_busy",     busy_o,             0);
    step();
    rstn_i = 1'b1;
    step();
    check("rstna_release", bram_rstna_o, 1);

    // Single read: BRAM[5], tag 3
    step(); drive(1, 5, 3);
    @(negedge clk_i);
    check("single_ena",   bram_ena_o,   1);
    check("single_addra", bram_addra_o, 5);
    step(); drive(0, 0, 0);
    @(negedge clk_i);
    check("single_regcea_t1", bram_regcea_o,      1);
    check("single_valid_t1",  lut_if.out_valid_o, 0);
    step();
    @(negedge clk_i);
    check("single_regcea_t2", bram_regcea_o,      0);
    check("single_valid_t2",  lut_if.out_valid_o, 0);
    step();
    @(negedge clk_i);
    check("single_valid_t3", lut_if.out_valid_o, 1);
    check("single_data",     lut_if.out_data_o,  32'hDEAD_BEEF);
    check("single_tag",      lut_if.out_tag_o,   3);
    step();
    @(negedge clk_i);
    check("single_idle", busy_o, 0);

    // Address wrap: 0xC + 0x6 -> 0x2
    step(); base_addr_i = 4'hC; drive(1, 6, 1);
    @(negedge clk_i);
    check("wrap_addra", bram_addra_o, 4'h2);
    step(); drive(0, 0, 0); base_addr_i = '0;
    wait_out(8);
    check("wrap_data", lut_if.out_data_o, 32'hC0DE_0002);
    check("wrap_tag",  lut_if.out_tag_o,  1);
    wait_idle(8);

    // Back-to-back: 8 requests, responses on consecutive cycles in order
    for (int c = 0; c < 11; c++) begin
      step();
      drive(c < 8, c, c);
      @(negedge clk_i);
      if (c < 8) check("b2b_in_ready", lut_if.in_ready_o, 1);
      if (c >= 3) begin
        check("b2b_out_valid", lut_if.out_valid_o, 1);
        check("b2b_out_tag",   lut_if.out_tag_o,   c - 3);
        check("b2b_out_data",  lut_if.out_data_o,  ram[c-3]);
      end
    end
    step(); drive(0, 0, 0);
    wait_idle(8);

    // Back-pressure: in_ready drops after exactly 4 issues, then drains
    lut_if.out_ready_i = 1'b0;
    for (int c = 0; c < 13; c++) begin
      step();
      drive(c < 6, 8 + c, 8 + c);
      lut_if.out_ready_i = (c >= 8);
      @(negedge clk_i);
      if (c < 6)  check("bp_in_ready", lut_if.in_ready_o, c < 4);
      if (c == 8) check("bp_in_ready_at_pop", lut_if.in_ready_o, 0);
      if (c == 9) check("bp_in_ready_after_pop", lut_if.in_ready_o, 1);
      if (c >= 8 && c < 12) begin
        check("bp_out_valid", lut_if.out_valid_o, 1);
        check("bp_out_tag",   lut_if.out_tag_o,   c);
      end
      if (c == 12) begin
        check("bp_drained_valid", lut_if.out_valid_o, 0);
        check("bp_drained_busy",  busy_o,             0);
      end
    end

    // Credits = 1: simultaneous issue and pop keeps in_ready high
    lut_if.out_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      drive(c < 3 || c == 6, 3 + c, 9);
      lut_if.out_ready_i = (c == 6);
      @(negedge clk_i);
      if (c == 6) begin
        check("cr1_in_ready_before", lut_if.in_ready_o,  1);
        check("cr1_out_valid",       lut_if.out_valid_o, 1);
        check("cr1_ena",             bram_ena_o,         1);
      end
      if (c == 7) check("cr1_in_ready_after", lut_if.in_ready_o, 1);
    end
    step(); drive(0, 0, 0); lut_if.out_ready_i = 1'b1;
    wait_idle(16);

    // Reset mid-flight: 2 queued in FIFO, 2 in the read pipeline
    lut_if.out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      drive(c < 4, 10 + c, c);
    end
    @(negedge clk_i);
    check("mid_full_in_ready", lut_if.in_ready_o,  0);
    check("mid_full_valid",    lut_if.out_valid_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    check("mid_rst_out_valid", lut_if.out_valid_o, 0);
    check("mid_rst_in_ready",  lut_if.in_ready_o,  1);
    check("mid_rst_busy",      busy_o,             0);
    step(); step();
    rstn_i = 1'b1;
    lut_if.out_ready_i = 1'b1;
    step(); drive(1, 9, 7);
    step(); drive(0, 0, 0);
    wait_out(8);
    check("post_rst_data", lut_if.out_data_o, ram[9]);
    check("post_rst_tag",  lut_if.out_tag_o,  7);
    wait_idle(8);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bram_lut_reader
